uart_core_param: RTL and testbench

Parametrised, synthesizable UART transceiver: one transmitter and one receiver sharing a clock, with configurable data width, parity, stop bits and bit period. It is the RTL counterpart of the serial `tx`/`rx` pair the UART environment drives and monitors, so the existing master/slave agents can run against real hardware. The parallel side uses valid/ready handshakes. The serial side is one `tx` output and one `rx` input.

---
 rtl/uart_core_param.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised UART transceiver (one TX, one RX, shared clock).
// Parallel side uses valid/ready on TX and a one-cycle valid pulse on RX; the
// serial side is a single tx output and a single rx input, both idle high.
module uart_core_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);

  // Last cycle of a bit period, and the cycle on which the start bit is
  // re-checked at its midpoint.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             PAR_ON    = (PARITY_EN != 0);
  localparam logic             PAR_INV   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_t              tx_state_q, tx_state_d;
  logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
  logic                   tx_stop_q, tx_stop_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_d;
  logic                   tx_cnt_end;
  logic                   tx_handshake;

  assign tx_cnt_end   = (tx_cnt_q == CNT_LAST);
  // Ready also in the final cycle of the last stop bit so that a queued word
  // starts its start bit with no idle cycle in between.
  assign tx_ready     = (tx_state_q == TX_IDLE) ||
                        ((tx_state_q == TX_STOP) && tx_cnt_end && (tx_stop_q == STOP_LAST));
  assign tx_handshake = tx_valid && tx_ready;
  assign tx_busy      = (tx_state_q != TX_IDLE);

  // TX next-state: bit timing, shifting and the line level for the next cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;

    case (tx_state_q)
      TX_START: begin
        if (tx_cnt_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_end) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == BIT_LAST) begin
            tx_stop_d  = 1'b0;
            tx_state_d = PAR_ON ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_cnt_end) begin
          tx_cnt_d   = '0;
          tx_stop_d  = 1'b0;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_end) begin
          tx_cnt_d = '0;
          if (tx_stop_q == STOP_LAST) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_stop_d = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A handshake overrides the end-of-frame return to idle.
    if (tx_handshake) begin
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_shift_d = tx_data;
      tx_par_d   = (^tx_data) ^ PAR_INV;
    end

    // Line level is registered from the next state so tx never glitches.
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // TX state register; reset parks the line high and abandons any frame.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx         <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx         <= tx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_s;

  // Two-flop synchroniser for the asynchronous rx line; resets to idle-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  rx_state_t              rx_state_q, rx_state_d;
  logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
  logic                   rx_stop_q, rx_stop_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_par_q, rx_par_d;
  logic                   rx_ferr_acc_q, rx_ferr_acc_d;
  logic [DATA_BITS-1:0]   rx_data_d;
  logic                   rx_valid_d;
  logic                   rx_perr_d;
  logic                   rx_ferr_d;
  logic                   rx_cnt_end;

  assign rx_cnt_end = (rx_cnt_q == CNT_LAST);
  assign rx_busy    = (rx_state_q != RX_IDLE);

  // RX next-state: start validation, mid-bit sampling, result and error flags.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_stop_d     = rx_stop_q;
    rx_shift_d    = rx_shift_q;
    rx_par_d      = rx_par_q;
    rx_ferr_acc_d = rx_ferr_acc_q;
    rx_data_d     = rx_data;
    rx_valid_d    = 1'b0;
    rx_perr_d     = rx_parity_err;
    rx_ferr_d     = rx_frame_err;

    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Midpoint re-check: a high line here was only a glitch.
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_bit_d      = '0;
            rx_ferr_acc_d = 1'b0;
            rx_state_d    = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) begin
            rx_stop_d  = 1'b0;
            rx_state_d = PAR_ON ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_cnt_end) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_s;
          rx_stop_d  = 1'b0;
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_end) begin
          rx_cnt_d = '0;
          if (rx_stop_q == STOP_LAST) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
            rx_perr_d  = PAR_ON && (rx_par_q != ((^rx_shift_q) ^ PAR_INV));
            rx_ferr_d  = rx_ferr_acc_q | ~rx_s;
            // A low stop bit means a break: wait for the line to recover
            // before hunting for the next start edge.
            rx_state_d = rx_ferr_d ? RX_WAIT_HIGH : RX_IDLE;
          end else begin
            rx_ferr_acc_d = rx_ferr_acc_q | ~rx_s;
            rx_stop_d     = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state register and result outputs; results hold until the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_stop_q     <= 1'b0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      rx_ferr_acc_q <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_stop_q     <= rx_stop_d;
      rx_shift_q    <= rx_shift_d;
      rx_par_q      <= rx_par_d;
      rx_ferr_acc_q <= rx_ferr_acc_d;
      rx_data       <= rx_data_d;
      rx_valid      <= rx_valid_d;
      rx_parity_err <= rx_perr_d;
      rx_frame_err  <= rx_ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: directed bench for uart_core_param. Instance u0 uses the
// default 8N1 configuration (optionally looped back tx->rx); instance u1 is
// 7 data bits with even parity for the parity-error cases.
module tb_uart_core_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance 0: default parameters
  logic [7:0] tx_data0;
  logic       tx_valid0, tx_ready0, tx0, tx_busy0;
  logic       rx0, rx_drv0, loopback;
  logic [7:0] rx_data0;
  logic       rx_valid0, rx_perr0, rx_ferr0, rx_busy0;

  // Instance 1: 7 data bits, even parity
  logic [6:0] tx_data1;
  logic       tx_valid1, tx_ready1, tx1, tx_busy1;
  logic       rx_drv1;
  logic [6:0] rx_data1;
  logic       rx_valid1, rx_perr1, rx_ferr1, rx_busy1;

  assign rx0 = loopback ? tx0 : rx_drv0;

  uart_core_param u0 (
    .clk(clk), .reset(reset),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .tx(tx0), .tx_busy(tx_busy0),
    .rx(rx0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_parity_err(rx_perr0), .rx_frame_err(rx_ferr0), .rx_busy(rx_busy0)
  );

  uart_core_param #(.DATA_BITS(7), .CLKS_PER_BIT(16), .PARITY_EN(1),
                    .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .tx(tx1), .tx_busy(tx_busy1),
    .rx(rx_drv1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_parity_err(rx_perr1), .rx_frame_err(rx_ferr1), .rx_busy(rx_busy1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Received words: [10]=frame_err, [9]=parity_err, [8:0]=data
  logic [10:0] q0[$];
  logic [10:0] q1[$];

  always @(negedge clk) begin
    if (rx_valid0) q0.push_back({rx_ferr0, rx_perr0, 1'b0, rx_data0});
    if (rx_valid1) q1.push_back({rx_ferr1, rx_perr1, 2'b00, rx_data1});
  end

  // Handshake one word into u0; returns 1 time unit after the handshake edge.
  task automatic start_tx(input logic [7:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!tx_ready0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("tx_ready_wait", 32'(tx_ready0), 1);
    tx_data0  = d;
    tx_valid0 = 1'b1;
    @(posedge clk);
    #1 tx_valid0 = 1'b0;
  endtask

  // Follow one 10-bit frame on tx0 (frame[0] = start bit) on negedges.
  task automatic watch_frame(input string tag, input logic [9:0] frame, output int ready_low);
    int match;
    ready_low = 0;
    for (int j = 0; j < 10; j++) begin
      match = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (tx0 === frame[j]) match++;
        if (tx_ready0 === 1'b0) ready_low++;
      end
      check($sformatf("%s_bit%0d", tag, j), 32'(match), 16);
    end
  endtask

  // Drive nbits on an rx line, LSB first, 16 cycles each.
  task automatic drive_bits(input int sel, input logic [15:0] bits, input int nbits);
    for (int j = 0; j < nbits; j++) begin
      if (sel == 0) rx_drv0 = bits[j];
      else          rx_drv1 = bits[j];
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rx(input string tag, input int sel, input int n);
    int waited;
    waited = 0;
    while (((sel == 0) ? q0.size() : q1.size()) < n && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check(tag, 32'((sel == 0) ? q0.size() : q1.size()), 32'(n));
  endtask

  logic [7:0]  words[3];
  logic [10:0] e;
  int          ready_low, gap, idx;

  initial begin
    words     = '{8'h00, 8'hFF, 8'h3C};
    reset     = 1'b0;
    tx_valid0 = 1'b0; tx_data0 = '0; rx_drv0 = 1'b1; loopback = 1'b0;
    tx_valid1 = 1'b0; tx_data1 = '0; rx_drv1 = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx",       32'(tx0),       1);
    check("rst_tx_ready", 32'(tx_ready0), 1);
    check("rst_tx_busy",  32'(tx_busy0),  0);
    check("rst_rx_data",  32'(rx_data0),  0);
    check("rst_rx_valid", 32'(rx_valid0), 0);
    check("rst_perr",     32'(rx_perr0),  0);
    check("rst_ferr",     32'(rx_ferr0),  0);
    check("rst_rx_busy",  32'(rx_busy0),  0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 frame: 0,1,0,1,0,0,1,0,1,1 -> 10'h34A
    start_tx(8'hA5);
    watch_frame("a5", 10'h34A, ready_low);
    check("a5_ready_low", 32'(ready_low), 159);
    check("a5_ready_last", 32'(tx_ready0), 1);
    @(negedge clk);
    check("a5_busy_after", 32'(tx_busy0), 0);
    check("a5_tx_idle", 32'(tx0), 1);

    // Loopback, three back-to-back words
    loopback = 1'b1;
    q0.delete();
    tx_data0  = words[0];
    tx_valid0 = 1'b1;
    @(posedge clk);
    #1 tx_data0 = words[1];
    idx = 1;
    gap = 0;
    for (int m = 1; m <= 480; m++) begin
      @(negedge clk);
      if (!tx_busy0) gap++;
      if (tx_ready0 && tx_valid0) begin
        @(posedge clk);
        #1 idx++;
        if (idx < 3) tx_data0 = words[idx];
        else         tx_valid0 = 1'b0;
      end
    end
    check("lb_handshakes", 32'(idx), 3);
    check("lb_gap", 32'(gap), 0);
    wait_rx("lb_count", 0, 3);
    for (int i = 0; i < 3; i++) begin
      e = (q0.size() > i) ? q0[i] : 11'h7FF;
      check($sformatf("lb_word%0d", i), 32'(e), 32'(words[i]));
    end
    loopback = 1'b0;

    // Parity: 0x55 with flipped parity bit (even parity would be 0)
    q1.delete();
    @(posedge clk);
    #1;
    drive_bits(1, 16'({2'b11, 7'h55, 1'b0}), 10);
    wait_rx("par_bad_count", 1, 1);
    e = (q1.size() > 0) ? q1[0] : 11'h7FF;
    check("par_bad_data", 32'(e[8:0]), 32'h55);
    check("par_bad_perr", 32'(e[9]), 1);
    check("par_bad_ferr", 32'(e[10]), 0);
    // 0x12 with correct even parity (two ones -> 0)
    drive_bits(1, 16'({2'b10, 7'h12, 1'b0}), 10);
    wait_rx("par_ok_count", 1, 2);
    e = (q1.size() > 1) ? q1[1] : 11'h7FF;
    check("par_ok_word", 32'(e), 32'h12);

    // Glitch: rx low for 4 cycles
    q0.delete();
    @(posedge clk);
    #1 rx_drv0 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_drv0 = 1'b1;
    @(negedge clk);
    check("glitch_busy_hi", 32'(rx_busy0), 1);
    repeat (30) @(negedge clk);
    check("glitch_busy_lo", 32'(rx_busy0), 0);
    check("glitch_no_valid", 32'(q0.size()), 0);

    // Break: rx low for 20 bit times
    @(posedge clk);
    #1 rx_drv0 = 1'b0;
    repeat (320) @(posedge clk);
    @(negedge clk);
    check("break_wait_high", 32'(rx_busy0), 1);
    wait_rx("break_count", 0, 1);
    e = (q0.size() > 0) ? q0[0] : 11'h7FF;
    check("break_data", 32'(e[8:0]), 0);
    check("break_ferr", 32'(e[10]), 1);
    check("break_perr", 32'(e[9]), 0);
    @(posedge clk);
    #1 rx_drv0 = 1'b1;
    repeat (5) @(negedge clk);
    check("break_idle", 32'(rx_busy0), 0);
    @(posedge clk);
    #1;
    drive_bits(0, 16'({1'b1, 8'h81, 1'b0}), 10);
    wait_rx("b81_count", 0, 2);
    e = (q0.size() > 1) ? q0[1] : 11'h7FF;
    check("b81_word", 32'(e), 32'h81);

    // Reset in the middle of data bit 2 of 0x5A (bit value 0)
    start_tx(8'h5A);
    repeat (56) @(negedge clk);
    check("pre_reset_tx", 32'(tx0), 0);
    reset = 1'b0;
    #1;
    check("reset_tx", 32'(tx0), 1);
    check("reset_busy", 32'(tx_busy0), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 32'(tx_ready0), 1);
    // 0xC3 frame: {1, C3, 0} -> 10'h386
    start_tx(8'hC3);
    watch_frame("c3", 10'h386, ready_low);
    check("c3_ready_low", 32'(ready_low), 159);
    check("c3_no_rx", 32'(q0.size()), 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
